rca_sum_accumulator: RTL

Downstream consumer of the 8-bit ripple-carry adder stage. It takes each adder result ({cout, sum}, a 9-bit value) over a valid/ready handshake and accumulates a programmable number of results into a saturating wide total. It then presents the total on an output valid/ready handshake. The block turns the adder into a streaming sum-of-sums engine that the bench or a later stage can drain.

---
 rtl/rca_sum_accumulator_pkg.sv | 15 +
 rtl/rca_sum_accumulator_if.sv | 31 +++
 rtl/rca_sum_accumulator_sat_add.sv | 19 +
 rtl/rca_sum_accumulator.sv | 84 ++++++++
 4 files changed

// File: rtl/rca_sum_accumulator_pkg.sv
// Shared types and constants for the ripple-carry adder datapath and its
// downstream sum accumulator.
package rca_pkg;

    // Accumulator control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    // Sum width of the upstream 8-bit ripple-carry adder stage.
    localparam int RCA_DATA_W = 8;

endpackage

// File: rtl/rca_sum_accumulator_if.sv
// Sample-in / total-out bundle of the sum accumulator.
// The master side drives samples and drains totals; the accumulator is the slave.
interface rca_sum_accumulator_if
    import rca_pkg::*;
#(
    parameter int DATA_W = RCA_DATA_W,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 4
) ();
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_sum;
    logic              in_cout;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic              sat;
    logic              busy;

    modport master (
        output start, in_valid, in_sum, in_cout, out_ready,
        input  in_ready, out_valid, acc, count, sat, busy
    );

    modport slave (
        input  start, in_valid, in_sum, in_cout, out_ready,
        output in_ready, out_valid, acc, count, sat, busy
    );
endinterface

// File: rtl/rca_sum_accumulator_sat_add.sv
// Combinational W-bit unsigned adder that clamps to all-ones on overflow.
// sat reports that the true sum did not fit in W bits.
module sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);
    logic [W:0] full;

    // One extra bit catches the carry out; a carry means the result clamps.
    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        sat  = full[W];
        sum  = full[W] ? '1 : full[W-1:0];
    end
endmodule

// File: rtl/rca_sum_accumulator.sv
// Streaming sum-of-sums engine: accepts N_SAMPLES adder results {cout, sum},
// accumulates them into a saturating ACC_W-bit total and offers the total
// on an output valid/ready handshake.
module rca_sum_accumulator
    import rca_pkg::*;
#(
    parameter int DATA_W    = RCA_DATA_W,
    parameter int ACC_W     = 16,
    parameter int N_SAMPLES = 8,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input logic                 clk,
    input logic                 rst,
    rca_sum_accumulator_if.slave bus
);
    acc_state_t       state, state_next;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sample;
    logic [ACC_W-1:0] add_sum;
    logic [CNT_W-1:0] count_q;
    logic             sat_q;
    logic             add_sat;
    logic             accept;
    logic             last;

    assign accept = (state == ACCUM) && bus.in_valid;
    assign last   = (count_q + CNT_W'(1)) == CNT_W'(N_SAMPLES);

    // Zero-extend the 9-bit adder result to accumulator width.
    always_comb begin
        sample           = '0;
        sample[DATA_W:0] = {bus.in_cout, bus.in_sum};
    end

    sat_add #(.W(ACC_W)) u_sat_add (
        .a   (acc_q),
        .b   (sample),
        .sum (add_sum),
        .sat (add_sat)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: start only counts in IDLE, so a start during the DONE
    // handshake is dropped and must be reasserted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start)      state_next = ACCUM;
            ACCUM:   if (accept && last) state_next = DONE;
            DONE:    if (bus.out_ready)  state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Total, sample count and sticky saturation flag; held outside ACCUM so
    // the last result stays readable in DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            acc_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (accept) begin
            acc_q   <= add_sum;
            count_q <= count_q + CNT_W'(1);
            if (add_sat) sat_q <= 1'b1;
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.acc       = acc_q;
    assign bus.count     = count_q;
    assign bus.sat       = sat_q;
endmodule
